// File: rtl/dt_host_ctrl.sv
// Host/pager for the 4-bit core running the paged decision-tree program.
// Decodes OPORT handshake words, serves features on IPORT, and switches ROM pages.
//
// state   | meaning
// IDLE    | core held in reset, waiting for start
// S_START | waiting for first symbol of a word
// OTH0    | got 2, waiting for second symbol
// OTH1    | got 2,1 (feature request prefix)
// OTH2    | got 2,0 (label 0/1 prefix)
// OP0     | got 1, waiting for second symbol
// OP1     | got 1,2 (page switch prefix)
// OP2     | got 1,0 (label 2/3 prefix)
// FWAIT   | feature request accepted, one dead cycle
// FREQ    | OPORT carries the feature index
// FFETCH  | feature on IPORT, waiting for ack (3)
// PRST    | one-cycle core reset for page change
// PFORCE  | BRANCH 0 forced until PC reaches 0
// PWAIT   | new page running, waiting for ack (3)
// FIN     | label latched, reporting done next cycle
module dt_host_ctrl #(
    parameter int DATA_LEN  = 4,
    parameter int PC_LEN    = 7,
    parameter int INSTR_LEN = 8,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 start,
    input  logic                 feat_we,
    input  logic [3:0]           feat_addr,
    input  logic [DATA_LEN-1:0]  feat_data,
    input  logic [DATA_LEN-1:0]  OPORT,
    input  logic [PC_LEN-1:0]    PC,
    input  logic [INSTR_LEN-1:0] rom_root,
    input  logic [INSTR_LEN-1:0] rom_left,
    input  logic [INSTR_LEN-1:0] rom_right,
    output logic [DATA_LEN-1:0]  IPORT,
    output logic [INSTR_LEN-1:0] INSTR,
    output logic                 core_rstn,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           label,
    output logic                 err
);
    typedef enum logic [3:0] {
        IDLE, S_START, OTH0, OTH1, OTH2, OP0, OP1, OP2,
        FWAIT, FREQ, FFETCH, PRST, PFORCE, PWAIT, FIN
    } state_t;

    typedef enum logic [1:0] {PG_ROOT, PG_LEFT, PG_RIGHT} page_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]        TMAX    = TW'(TIMEOUT - 1);
    localparam logic [INSTR_LEN-1:0] BRANCH0 = INSTR_LEN'(8'h80);

    state_t                state_q, state_d;
    page_t                 page_q, page_d;
    logic [DATA_LEN-1:0]   iport_q, iport_d;
    logic                  core_rstn_q, core_rstn_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            label_q, label_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_LEN-1:0]   feat [16];
    logic [1:0]            olow;

    assign olow = OPORT[1:0];

    // Feature table has no reset so its contents survive an aborted run.
    always_ff @(posedge CLK) begin
        if (feat_we && !busy_q) feat[feat_addr] <= feat_data;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            page_q      <= PG_ROOT;
            iport_q     <= '0;
            core_rstn_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            label_q     <= 2'd0;
            err_q       <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            iport_q     <= iport_d;
            core_rstn_q <= core_rstn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            label_q     <= label_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        iport_d     = iport_q;
        core_rstn_d = core_rstn_q;
        busy_d      = busy_q;
        done_d      = done_q;
        label_d     = label_q;
        err_d       = err_q;
        case (state_q)
            IDLE: if (start) begin
                state_d     = S_START;
                page_d      = PG_ROOT;
                done_d      = 1'b0;
                err_d       = 1'b0;
                label_d     = 2'd0;
                core_rstn_d = 1'b1;
                busy_d      = 1'b1;
            end
            S_START: if (olow == 2'd1) state_d = OP0;
                     else if (olow == 2'd2) state_d = OTH0;
            OTH0: if (olow == 2'd0) state_d = OTH2;
                  else if (olow == 2'd1) state_d = OTH1;
            OTH1: if (olow == 2'd2) state_d = FWAIT;
            OTH2: if (olow == 2'd1) begin state_d = FIN; label_d = 2'd0; end
                  else if (olow == 2'd2) begin state_d = FIN; label_d = 2'd1; end
            OP0: if (olow == 2'd0) state_d = OP2;
                 else if (olow == 2'd2) state_d = OP1;
            OP1: if (olow == 2'd0) begin state_d = PRST; page_d = PG_LEFT; core_rstn_d = 1'b0; end
                 else if (olow == 2'd1) begin state_d = PRST; page_d = PG_RIGHT; core_rstn_d = 1'b0; end
            OP2: if (olow == 2'd1) begin state_d = FIN; label_d = 2'd3; end
                 else if (olow == 2'd2) begin state_d = FIN; label_d = 2'd2; end
            FWAIT: state_d = FREQ;
            FREQ: begin
                iport_d = feat[OPORT[3:0]];
                state_d = FFETCH;
            end
            FFETCH: if (olow == 2'd3) state_d = S_START;
            PRST: begin
                core_rstn_d = 1'b1;
                state_d     = PFORCE;
            end
            PFORCE: if (PC == '0) state_d = PWAIT;
            PWAIT: if (olow == 2'd3) state_d = S_START;
            FIN: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                core_rstn_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Watchdog wins over any handshake progress on the expiring cycle.
        if (busy_q && timer_q == TMAX) begin
            state_d     = IDLE;
            err_d       = 1'b1;
            busy_d      = 1'b0;
            core_rstn_d = 1'b0;
        end
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) timer_d = '0;
        else if (busy_q)        timer_d = timer_q + 1'b1;
    end

    always_comb begin
        INSTR = rom_root;
        if (state_q == IDLE)        INSTR = '0;
        else if (state_q == PFORCE) INSTR = BRANCH0;
        else begin
            case (page_q)
                PG_LEFT:  INSTR = rom_left;
                PG_RIGHT: INSTR = rom_right;
                default:  INSTR = rom_root;
            endcase
        end
    end

    assign IPORT     = iport_q;
    assign core_rstn = core_rstn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign label     = label_q;
    assign err       = err_q;
endmodule

// File: tb/tb_dt_host_ctrl.sv
// Bench for dt_host_ctrl: drives handshake words as a core would and checks
// against a word-level model (feature table, current page, label table).
module tb_dt_host_ctrl;
    localparam int TIMEOUT = 4096;

    logic       CLK = 1'b0, RSTN = 1'b0, start = 1'b0, feat_we = 1'b0;
    logic [3:0] feat_addr = '0, feat_data = '0, OPORT = '0;
    logic [6:0] PC = '0;
    logic [7:0] rom_root = '0, rom_left = '0, rom_right = '0;
    logic [3:0] IPORT;
    logic [7:0] INSTR;
    logic       core_rstn, busy, done, err;
    logic [1:0] label;

    int checks = 0, errors = 0;
    logic [3:0] feat_m [16];
    int page_m = 0;

    dt_host_ctrl #(.DATA_LEN(4), .PC_LEN(7), .INSTR_LEN(8), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RSTN(RSTN), .start(start), .feat_we(feat_we),
        .feat_addr(feat_addr), .feat_data(feat_data), .OPORT(OPORT), .PC(PC),
        .rom_root(rom_root), .rom_left(rom_left), .rom_right(rom_right),
        .IPORT(IPORT), .INSTR(INSTR), .core_rstn(core_rstn), .busy(busy),
        .done(done), .label(label), .err(err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] instr_exp();
        if (page_m == 1) return rom_left;
        if (page_m == 2) return rom_right;
        return rom_root;
    endfunction

    // Label words: 1,0,x -> 3/2 and 2,0,x -> 0/1 for x = 1/2.
    function automatic logic [1:0] label_of(input logic [1:0] a, input logic [1:0] c);
        if (a == 2'd1) return (c == 2'd1) ? 2'd3 : 2'd2;
        return (c == 2'd1) ? 2'd0 : 2'd1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [1:0] code);
        OPORT = {2'($urandom_range(0, 3)), code};
        tick();
    endtask

    // Code 3 is only meaningful as an acknowledge, so it is a no-op mid-word.
    task automatic noise();
        repeat ($urandom_range(0, 2)) send(2'd3);
    endtask

    task automatic rom_rand();
        rom_root = 8'($urandom); rom_left = 8'($urandom); rom_right = 8'($urandom);
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
        page_m = 0;
    endtask

    task automatic idle_write(input logic [3:0] a, input logic [3:0] d);
        feat_we = 1'b1; feat_addr = a; feat_data = d; tick(); feat_we = 1'b0;
        feat_m[a] = d;
    endtask

    task automatic word_feature(input logic [3:0] idx);
        noise(); send(2'd2); noise(); send(2'd1); noise(); send(2'd2);
        OPORT = 4'($urandom); tick();
        OPORT = idx; tick();
        if (IPORT !== feat_m[idx]) begin errors++; $display("FAIL feat_read idx=%0d got=%h exp=%h", idx, IPORT, feat_m[idx]); end
        checks++;
        repeat ($urandom_range(0, 2)) send(2'($urandom_range(0, 2)));
        send(2'd3);
        rom_rand(); #1;
        if (IPORT !== feat_m[idx] || INSTR !== instr_exp()) begin
            errors++; $display("FAIL feat_hold iport=%h exp=%h instr=%h exp=%h", IPORT, feat_m[idx], INSTR, instr_exp());
        end
        checks++;
    endtask

    task automatic word_page(input bit right);
        int k;
        noise(); send(2'd1); noise(); send(2'd2); noise(); send(right ? 2'd1 : 2'd0);
        page_m = right ? 2 : 1;
        rom_rand(); #1;
        if (core_rstn !== 1'b0 || INSTR !== instr_exp()) begin
            errors++; $display("FAIL prst core_rstn=%b instr=%h exp_instr=%h", core_rstn, INSTR, instr_exp());
        end
        checks++;
        k = $urandom_range(0, 7);
        PC = 7'(k); tick();
        if (core_rstn !== 1'b1) begin errors++; $display("FAIL pforce_rstn got=%b exp=1", core_rstn); end
        checks++;
        for (int p = k; p >= 0; p--) begin
            PC = 7'(p); #1;
            if (INSTR !== 8'h80) begin errors++; $display("FAIL pforce_instr pc=%0d got=%h exp=80", p, INSTR); end
            checks++;
            tick();
        end
        PC = 7'($urandom); rom_rand(); #1;
        if (INSTR !== instr_exp()) begin errors++; $display("FAIL pwait_instr got=%h exp=%h", INSTR, instr_exp()); end
        checks++;
        repeat ($urandom_range(0, 2)) send(2'($urandom_range(0, 2)));
        send(2'd3);
        if (busy !== 1'b1 || core_rstn !== 1'b1) begin errors++; $display("FAIL page_ack busy=%b core_rstn=%b exp=1,1", busy, core_rstn); end
        checks++;
    endtask

    task automatic word_label(input logic [1:0] a, input logic [1:0] c);
        logic [1:0] exp_l;
        exp_l = label_of(a, c);
        noise(); send(a); noise(); send(2'd0); noise(); send(c);
        tick();
        if (done !== 1'b1 || label !== exp_l || busy !== 1'b0 || core_rstn !== 1'b0 || INSTR !== 8'h00) begin
            errors++;
            $display("FAIL label_done done=%b label=%0d exp_label=%0d busy=%b core_rstn=%b instr=%h (exp 1,%0d,0,0,00)",
                     done, label, exp_l, busy, core_rstn, INSTR, exp_l);
        end
        checks++;
    endtask

    task automatic test_reset();
        RSTN = 1'b0; start = 1'b1;
        tick(); tick();
        start = 1'b0;
        if (busy !== 0 || done !== 0 || label !== 0 || err !== 0 || core_rstn !== 0 || IPORT !== 0 || INSTR !== 0) begin
            errors++; $display("FAIL reset_state busy=%b done=%b label=%0d err=%b core_rstn=%b iport=%h instr=%h (exp all 0)",
                               busy, done, label, err, core_rstn, IPORT, INSTR);
        end
        checks++;
        RSTN = 1'b1; tick();
        for (int i = 0; i < 16; i++) idle_write(4'(i), 4'($urandom));
    endtask

    task automatic test_feature_path();
        idle_write(4'd5, 4'hA);
        do_start();
        if (busy !== 1'b1 || core_rstn !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL start busy=%b core_rstn=%b done=%b exp=1,1,0", busy, core_rstn, done);
        end
        checks++;
        word_feature(4'd5);
        word_label(2'd1, 2'd1);
    endtask

    task automatic test_reset_mid();
        do_start();
        send(2'd1);
        #2 RSTN = 1'b0;
        #1;
        if (busy !== 0 || done !== 0 || label !== 0 || err !== 0 || core_rstn !== 0 || IPORT !== 0 || INSTR !== 0) begin
            errors++; $display("FAIL reset_mid busy=%b done=%b label=%0d err=%b core_rstn=%b iport=%h instr=%h (exp all 0)",
                               busy, done, label, err, core_rstn, IPORT, INSTR);
        end
        checks++;
        tick(); RSTN = 1'b1; tick();
        do_start();
        word_feature(4'd5);
        word_label(2'd2, 2'd2);
    endtask

    task automatic test_root_path();
        do_start();
        rom_rand(); #1;
        if (INSTR !== rom_root) begin errors++; $display("FAIL root_instr got=%h exp=%h", INSTR, rom_root); end
        checks++;
        word_page(1'b0);
        word_label(2'd1, 2'd2);
        do_start();
        word_label(2'd2, 2'd1);
    endtask

    task automatic test_busy_ignore();
        logic [3:0] idx;
        idx = 4'($urandom);
        idle_write(4'd7, 4'h3);
        start = 1'b1; feat_we = 1'b1; feat_addr = 4'd7; feat_data = 4'hC; tick();
        start = 1'b0; feat_we = 1'b0; feat_m[7] = 4'hC; page_m = 0;
        word_feature(4'd7);
        send(2'd2);
        start = 1'b1; feat_we = 1'b1; feat_addr = idx; feat_data = ~feat_m[idx];
        send(2'd1);
        start = 1'b0; feat_we = 1'b0;
        if (busy !== 1'b1) begin errors++; $display("FAIL start_while_busy busy=%b exp=1", busy); end
        checks++;
        send(2'd2);
        OPORT = 4'($urandom); tick();
        OPORT = idx; tick();
        if (IPORT !== feat_m[idx]) begin errors++; $display("FAIL busy_write_dropped idx=%0d got=%h exp=%h", idx, IPORT, feat_m[idx]); end
        checks++;
        send(2'd3);
        word_label(2'd2, 2'd2);
    endtask

    task automatic test_watchdog();
        do_start();
        word_page(1'b1);
        send(2'd2); send(2'd1);
        OPORT = 4'h0;
        repeat (TIMEOUT - 1) tick();
        if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wd_early err=%b busy=%b exp=0,1", err, busy); end
        checks++;
        tick();
        if (err !== 1'b1 || busy !== 1'b0 || core_rstn !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL wd_expire err=%b busy=%b core_rstn=%b done=%b exp=1,0,0,0", err, busy, core_rstn, done);
        end
        checks++;
        do_start();
        rom_rand(); #1;
        if (err !== 1'b0 || busy !== 1'b1 || INSTR !== rom_root) begin
            errors++; $display("FAIL wd_restart err=%b busy=%b instr=%h exp=0,1,%h", err, busy, INSTR, rom_root);
        end
        checks++;
        word_label(2'd1, 2'd1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 1) == 1) idle_write(4'($urandom), 4'($urandom));
            do_start();
            repeat ($urandom_range(0, 3)) begin
                if ($urandom_range(0, 1) == 1) word_feature(4'($urandom));
                else word_page(1'($urandom));
            end
            word_label(2'($urandom_range(1, 2)), 2'($urandom_range(1, 2)));
        end
    endtask

    initial begin
        rom_rand();
        test_reset();
        test_feature_path();
        test_reset_mid();
        test_root_path();
        test_busy_ignore();
        test_random();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
